// File: rtl/mux_lut_unit.sv
// K-input LUT over W lanes: serial-loaded truth table drives a 2:1 mux tree per lane, valid/ready output.
// Latency 1 (2 with MUX_LUT_OUT_REG_EN); per-stage ready = !valid || downstream ready.
module mux2_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module mux_lut_unit #(
  parameter int K = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_bit,
  output logic           cfg_done,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K*W-1:0] in_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_y
);
  localparam int N     = 1 << K;
  localparam int NODES = 2 * N - 1;
  localparam logic [K-1:0] LAST = K'(N - 1);

  localparam logic [1:0] UNCONF  = 2'd0;
  localparam logic [1:0] LOADING = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  logic [1:0]   state;
  logic [K-1:0] cnt;
  logic         commit;
  logic [N-1:0] shadow;
  logic [N-1:0] lut;

  // The last bit only arms the commit; the copy to the live table happens one edge later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= UNCONF;
      cnt    <= '0;
      commit <= 1'b0;
      shadow <= '0;
      lut    <= '0;
    end else if (cfg_start) begin
      state  <= LOADING;
      cnt    <= '0;
      commit <= 1'b0;
      shadow <= '0;
    end else if (commit) begin
      lut    <= shadow;
      state  <= ACTIVE;
      commit <= 1'b0;
    end else if (state == LOADING && cfg_valid) begin
      shadow[cnt] <= cfg_bit;
      cnt         <= cnt + K'(1);
      if (cnt == LAST) commit <= 1'b1;
    end
  end

  assign cfg_done = (state == ACTIVE);

  logic [W-1:0] y_comb;

  // Heap-ordered tree: node 0 is the root (selects on x_{K-1}), leaves hold lut[0..N-1] left to right.
  for (genvar i = 0; i < W; i++) begin : g_lane
    logic [NODES-1:0] node;
    for (genvar l = 0; l < N; l++) begin : g_leaf
      assign node[N-1+l] = lut[l];
    end
    for (genvar d = 0; d < K; d++) begin : g_lvl
      for (genvar j = 0; j < (1 << d); j++) begin : g_cell
        localparam int NI = (1 << d) - 1 + j;
        mux2_cell u_mux (
          .a(node[2*NI+1]),
          .b(node[2*NI+2]),
          .s(in_x[(K-1-d)*W+i]),
          .y(node[NI])
        );
      end
    end
    assign y_comb[i] = node[0];
  end

  logic         s1_vld;
  logic         s1_rdy;
  logic [W-1:0] s1_dat;

  assign in_ready = (state == ACTIVE) && (!s1_vld || s1_rdy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (!s1_vld || s1_rdy) begin
      s1_vld <= in_valid && in_ready;
      if (in_valid && in_ready) s1_dat <= y_comb;
    end
  end

`ifdef MUX_LUT_OUT_REG_EN
  logic         s2_vld;
  logic [W-1:0] s2_dat;

  assign s1_rdy = !s2_vld || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else if (s1_rdy) begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_dat <= s1_dat;
    end
  end

  assign out_valid = s2_vld;
  assign out_y     = s2_dat;
`else
  assign s1_rdy    = out_ready;
  assign out_valid = s1_vld;
  assign out_y     = s1_dat;
`endif

endmodule

// File: tb/tb_mux_lut_unit.sv
// Scoreboard bench for mux_lut_unit (K=2, W=8): directed table loads and operand streams.
module tb_mux_lut_unit;
  localparam int K = 2;
  localparam int W = 8;
`ifdef MUX_LUT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_start, cfg_valid, cfg_bit, cfg_done;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [K*W-1:0] in_x;
  logic [W-1:0]   out_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W-1:0] sbq[$];
  int pop_cyc[$];

  mux_lut_unit #(.K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard head, pops on transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected no output", out_y);
      end else begin
        chk(out_ready ? "result" : "hold", 32'(out_y), 32'(sbq[0]));
        if (out_ready) begin
          void'(sbq.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic start_cfg();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic shift(input logic b);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic load4(input logic [3:0] b);
    start_cfg();
    for (int i = 0; i < 4; i++) begin
      shift(b[i]);
      chk("cfg_done_during_load", 32'(cfg_done), 32'd0);
    end
    @(posedge clk); #1;
    chk("cfg_done_after_load", 32'(cfg_done), 32'd1);
    chk("in_ready_after_load", 32'(in_ready), 32'd1);
  endtask

  task automatic send1(input logic [K*W-1:0] x, input logic [W-1:0] y);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_x     = x;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    else sbq.push_back(y);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b1; in_x = 16'hCCF0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y",     32'(out_y),     32'h00);
    chk("rst_cfg_done",  32'(cfg_done),  32'd0);
    repeat (3) @(posedge clk); #1;
    chk("noconf_in_ready",  32'(in_ready),  32'd0);
    chk("noconf_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // AND table, then a stray cfg_valid while ACTIVE must be ignored
    load4(4'b1000);
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    send1(16'hCCF0, 8'hC0);
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("and_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // XOR table, with a restart after two bits
    start_cfg();
    shift(1'b1);
    shift(1'b1);
    chk("cfg_done_partial", 32'(cfg_done), 32'd0);
    load4(4'b0110);
    send1(16'hCCF0, 8'h3C);
    in_valid = 1'b0;
    drain();

    // Back-to-back stream
    pop_cyc.delete();
    send1(16'hFF00, 8'hFF);
    send1(16'hAA55, 8'hFF);
    send1(16'h0F0F, 8'h00);
    send1(16'h1234, 8'h26);
    in_valid = 1'b0;
    drain();
    chk("stream_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4)
      for (int i = 0; i < 3; i++) chk("stream_consecutive", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd1);

    // Back-pressure for 5 cycles
    out_ready = 1'b0;
    fork
      begin
        send1(16'hF00F, 8'hFF);
        send1(16'h8118, 8'h99);
        send1(16'h3330, 8'h03);
        send1(16'h7711, 8'h66);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready",  32'(in_ready),  32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a load
    start_cfg();
    shift(1'b1);
    shift(1'b0);
    shift(1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_cfg_done",  32'(cfg_done),  32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_y",     32'(out_y),     32'h00);
    in_valid = 1'b1;
    in_x     = 16'hCCF0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_blocked_ready", 32'(in_ready),  32'd0);
      chk("midrst_blocked_valid", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_lut_unit.md
# mux_lut_unit

Parametrised, pipelined lookup-table logic unit that evaluates any K-input Boolean function on W independent bit lanes, using a 2^K:1 mux tree per lane driven by a run-time-loadable truth table. It generalises the fixed two-input mux gate primitive. The function is programmed through a serial config port, and data flows through a valid/ready stream stage. It sits between a combinational operand source and any ready-capable consumer.

## Interface
- `K`, default 2: number of function inputs per lane (1..4); truth table is 2^K bits.
- `W`, default 8: number of independent lanes.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cfg_start` input 1: one-cycle pulse; begins (or restarts) truth-table load.
- `cfg_valid` input 1: `cfg_bit` is valid this cycle.
- `cfg_bit` input 1: serial truth-table bit, index 0 first.
- `cfg_done` output 1: high while a complete table is active (state ACTIVE).
- `in_valid` input 1: operand word valid.
- `in_ready` output 1: unit accepts operand this cycle.
- `in_x` input K*W: operands; input j of lane i is `in_x[j*W+i]`; input 0 is the LSB of the table index.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `out_y` output W: result; `out_y[i] = table[{x_{K-1}..x_0} of lane i]`.

## Operation
- States: UNCONF, LOADING, ACTIVE.
- UNCONF → LOADING on `cfg_start`. ACTIVE → LOADING on `cfg_start`. LOADING → LOADING (counter cleared) on `cfg_start`; `cfg_start` has priority over a same-cycle `cfg_valid`, and that bit is dropped.
- LOADING: each `cfg_valid` writes `cfg_bit` into shadow table at `cnt`; `cnt` increments. When the 2^K-th bit is written, the shadow table is copied atomically to the active table the next cycle, and the state becomes ACTIVE.
- `cfg_valid` outside LOADING is ignored.
- The active table never changes mid-load. A partially loaded shadow is discarded on restart.
- Evaluation: per lane, a 2^K:1 mux tree built from 2:1 mux cells, selected by the lane's K operand bits, with data inputs from the active table.
- `in_ready` = (state == ACTIVE) && pipeline can advance. Transfer occurs when `in_valid && in_ready`.
- An output stage holding a valid result keeps `out_y` stable until `out_valid && out_ready`.
- Results already in the pipeline when LOADING begins still drain. They were computed with the old table.
- Reset values: state UNCONF; `cnt` 0; shadow and active tables 0; `cfg_done` 0; `in_ready` 0; `out_valid` 0; `out_y` 0.

## Timing
- Config: the last table bit is written at edge N. `cfg_done` is high and `in_ready` may assert after edge N+1.
- Latency: an operand accepted at edge T gives `out_valid`=1 with result after edge T+1 (base) or T+2 (with the macro below).
- Throughput: 1 result/cycle while `out_ready`=1. `in_ready` = `!out_valid || out_ready` per stage, with no combinational path from `in_valid` to `out_valid`.
- Simultaneous accept-out and accept-in: the stage reloads in the same edge with no bubble.
- `rst_n`=0 mid-load or mid-stream: all state returns to reset values at that edge. In-flight results are lost. Table contents are cleared to 0.
- Back-pressure: `out_ready`=0 for any duration holds `out_y`/`out_valid` unchanged and stalls the input once full.

## Configuration
- `MUX_LUT_OUT_REG_EN` defined: adds a second register stage after the mux tree. Latency is 2, the pipeline holds up to 2 results, and ready propagates stage by stage.
- Undefined: single output register. Latency is 1, the pipeline holds 1 result.
- Handshake rules and results are identical in both builds; only latency and capacity differ.

## Test plan
- Reset, then `in_valid`=1 with no config: `in_ready`=0, `out_valid`=0, `out_y`=8'h00, `cfg_done`=0.
- K=2, W=8. Load bits 0,0,0,1 (AND). Then `in_x`={8'hCC,8'hF0}: `out_y`=8'hC0 after 1 cycle (2 with the macro).
- Reload bits 0,1,1,0 (XOR) with one `cfg_start` restart after 2 bits, then 4 bits. Same operands: `out_y`=8'h3C. `cfg_done` is low during load and high after the last bit +1.
- Stream 4 operands back-to-back, `out_ready`=1: 4 results on consecutive cycles, in order.
- Stream with `out_ready`=0 for 5 cycles: `out_y` held stable, `in_ready`=0 once full, no loss or duplication on release.
- Assert `rst_n`=0 during LOADING after 3 bits: state UNCONF, `cfg_done`=0, and `out_y`=8'h00 on later operands is blocked because `in_ready`=0.
